mem_sweep_bist: RTL

Hardware memory sweep self-test engine on the CPU data/address bus. On `start`, it pauses the CPU core and writes a configurable pattern across a window of RAM. It then reads the window back and compares each location, reporting pass/fail and error statistics. It generalises the bench-side write-then-read sweep into synthesizable RTL, with configurable widths, window, pattern modes and abort.

---
 rtl/mem_sweep_bist_if.sv | 29 ++
 rtl/mem_sweep_bist.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_sweep_bist_if
// Description : CPU data/address bus as seen by the sweep engine (master)
//               and the RAM / bus fabric (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_sweep_bist_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  cpu_pause;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_we;
   logic                  mem_oe;

   modport master (
      output cpu_pause, mem_addr, mem_wdata, mem_we, mem_oe,
      input  mem_rdata
   );

   modport slave (
      input  cpu_pause, mem_addr, mem_wdata, mem_we, mem_oe,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_sweep_bist.sv
`default_nettype none
// ============================================================================
// Module      : mem_sweep_bist
// Description : Write-then-read memory sweep self-test on the CPU bus.
//               Define MEM_SWEEP_ERR_LOG_EN to implement first-error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sweep_bist #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  start,
   input  wire logic                  abort,
   input  wire logic [1:0]            mode,
   input  wire logic [ADDR_WIDTH-1:0] base_addr,
   input  wire logic [ADDR_WIDTH-1:0] depth,
   mem_sweep_bist_if.master           bus,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [CNT_WIDTH-1:0]       err_count,
   output logic [ADDR_WIDTH-1:0]      first_err_addr,
   output logic [DATA_WIDTH-1:0]      first_err_exp,
   output logic [DATA_WIDTH-1:0]      first_err_act
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PAUSE   = 3'd1,
      S_WRITE   = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_CMP  = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_mode, w_mode_nxt;
   logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
   logic [ADDR_WIDTH-1:0] r_depth, w_depth_nxt;
   logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
   logic [CNT_WIDTH-1:0]  r_err_count, w_err_nxt;
   logic                  w_capture, w_clear_log;
   logic [DATA_WIDTH-1:0] w_exp;
   logic                  w_last;
   logic                  w_active, w_on_bus;

   logic                  r_pause, r_we, r_oe, r_busy, r_done, r_pass;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;

   // Pattern for location i; i is replicated across the data width.
   function automatic logic [DATA_WIDTH-1:0] f_pattern(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic [1:0]            m
   );
      logic [DATA_WIDTH-1:0] rep;
      logic [DATA_WIDTH-1:0] p;
      for (int b = 0; b < DATA_WIDTH; b++) rep[b] = idx[b % ADDR_WIDTH];
      p = '0;
      case (m)
         2'd0: p = ~rep;
         2'd1: p = rep;
         2'd2: for (int b = 0; b < DATA_WIDTH; b++) p[b] = ((b % 2) == 0) ^ idx[0];
         default: p = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (idx % DATA_WIDTH);
      endcase
      return p;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_base_nxt  = r_base;
      w_depth_nxt = r_depth;
      w_idx_nxt   = r_idx;
      w_err_nxt   = r_err_count;
      w_capture   = 1'b0;
      w_clear_log = 1'b0;
      w_exp       = f_pattern(r_idx, r_mode);
      w_last      = (r_idx == r_depth - 1'b1);

      if (abort && r_state != S_IDLE) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start && !abort) begin
                  w_mode_nxt  = mode;
                  w_base_nxt  = base_addr;
                  w_depth_nxt = depth;
                  w_idx_nxt   = '0;
                  w_err_nxt   = '0;
                  w_clear_log = 1'b1;
                  w_state_nxt = S_PAUSE;
               end
            end
            S_PAUSE: begin
               w_idx_nxt   = '0;
               w_state_nxt = (r_depth == '0) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
               if (w_last) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_RD_ADDR;
               end else begin
                  w_idx_nxt   = r_idx + 1'b1;
               end
            end
            S_RD_ADDR: w_state_nxt = S_RD_CMP;
            S_RD_CMP: begin
               if (bus.mem_rdata != w_exp) begin
                  if (r_err_count != '1) w_err_nxt = r_err_count + 1'b1;
                  w_capture = (r_err_count == '0);
               end
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_state_nxt = S_RD_ADDR;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      w_active = (w_state_nxt == S_PAUSE) || (w_state_nxt == S_WRITE) ||
                 (w_state_nxt == S_RD_ADDR) || (w_state_nxt == S_RD_CMP);
      w_on_bus = (w_state_nxt == S_WRITE) || (w_state_nxt == S_RD_ADDR) ||
                 (w_state_nxt == S_RD_CMP);
   end

   // Bus outputs are computed from the next state so every output is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mode      <= '0;
         r_base      <= '0;
         r_depth     <= '0;
         r_idx       <= '0;
         r_err_count <= '0;
         r_pause     <= 1'b0;
         r_busy      <= 1'b0;
         r_we        <= 1'b0;
         r_oe        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode      <= w_mode_nxt;
         r_base      <= w_base_nxt;
         r_depth     <= w_depth_nxt;
         r_idx       <= w_idx_nxt;
         r_err_count <= w_err_nxt;
         r_pause     <= w_active;
         r_busy      <= w_active;
         r_we        <= (w_state_nxt == S_WRITE);
         r_oe        <= (w_state_nxt == S_RD_ADDR) || (w_state_nxt == S_RD_CMP);
         r_addr      <= w_on_bus ? (w_base_nxt + w_idx_nxt) : '0;
         r_wdata     <= (w_state_nxt == S_WRITE) ? f_pattern(w_idx_nxt, w_mode_nxt) : '0;
         r_done      <= (w_state_nxt == S_DONE);
         r_pass      <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
      end
   end

`ifdef MEM_SWEEP_ERR_LOG_EN
   logic [ADDR_WIDTH-1:0] r_fe_addr;
   logic [DATA_WIDTH-1:0] r_fe_exp, r_fe_act;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fe_addr <= '0;
         r_fe_exp  <= '0;
         r_fe_act  <= '0;
      end else if (w_clear_log) begin
         r_fe_addr <= '0;
         r_fe_exp  <= '0;
         r_fe_act  <= '0;
      end else if (w_capture) begin
         r_fe_addr <= r_addr;
         r_fe_exp  <= w_exp;
         r_fe_act  <= bus.mem_rdata;
      end
   end

   assign first_err_addr = r_fe_addr;
   assign first_err_exp  = r_fe_exp;
   assign first_err_act  = r_fe_act;
`else
   assign first_err_addr = '0;
   assign first_err_exp  = '0;
   assign first_err_act  = '0;
`endif

   assign bus.cpu_pause = r_pause;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_we    = r_we;
   assign bus.mem_oe    = r_oe;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign err_count     = r_err_count;

endmodule
`default_nettype wire
